// File: rtl/frame_playback_if.sv
// Signal bundle between frame_playback, the VGA timing source and the frame memory.
// Read request: oMemRE qualifies oMemAddr for exactly one cycle; memory never stalls
// and presents the word on iMemData exactly RD_LAT cycles later, no ready needed.
interface frame_playback_if;
  logic        iSwitch;
  logic        iReady;
  logic [12:0] iX;
  logic [12:0] iY;
  logic [19:0] oMemAddr;
  logic        oMemRE;
  logic [15:0] iMemData;
  logic [9:0]  oRed;
  logic [9:0]  oGreen;
  logic [9:0]  oBlue;
  logic        oActive;
  logic        oBusy;
  logic        oLed;
  logic [1:0]  oState;

  modport master (
    input  iSwitch, iReady, iX, iY, iMemData,
    output oMemAddr, oMemRE, oRed, oGreen, oBlue, oActive, oBusy, oLed, oState
  );

  modport slave (
    output iSwitch, iReady, iX, iY, iMemData,
    input  oMemAddr, oMemRE, oRed, oGreen, oBlue, oActive, oBusy, oLed, oState
  );
endinterface

// File: rtl/frame_playback.sv
// Replays a stored intensity frame onto live VGA timing: one memory read per
// active pixel, returned data shown as grey on all three colour channels.
module frame_playback #(
  parameter int H_START = 144,
  parameter int V_START = 35,
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int RD_LAT  = 2   // legal 1..4
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  frame_playback_if.master bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, PLAY = 2'd2} state_t;

  localparam logic [12:0] X_LO       = 13'(H_START);
  localparam logic [12:0] X_HI       = 13'(H_START + H_RES - 1);
  localparam logic [12:0] Y_LO       = 13'(V_START);
  localparam logic [12:0] Y_HI       = 13'(V_START + V_RES - 1);
  localparam logic [19:0] LINE_WORDS = 20'(H_RES);

  state_t            state;
  logic              fb;
  logic              run;
  logic              in_win;
  logic              hit;
  logic [12:0]       x_off;
  logic [12:0]       y_off;
  logic [19:0]       addr;
  logic [RD_LAT-1:0] vpipe;
  logic              unused_hi;

  assign fb        = (bus.iX == 13'd0) && (bus.iY == 13'd0);
  assign run       = bus.iSwitch && bus.iReady;
  assign in_win    = (bus.iX >= X_LO) && (bus.iX <= X_HI) &&
                     (bus.iY >= Y_LO) && (bus.iY <= Y_HI);
  assign hit       = (state == PLAY) && in_win;
  assign x_off     = bus.iX - X_LO;
  assign y_off     = bus.iY - Y_LO;
  assign addr      = 20'(x_off) + LINE_WORDS * 20'(y_off);
  assign unused_hi = ^bus.iMemData[15:10];
  assign bus.oState = state;

  // Dropping the request while ARMED cancels even on the FB cycle; in PLAY the
  // request is only looked at on FB, so a started frame always completes.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state    <= IDLE;
      bus.oBusy <= 1'b0;
      bus.oLed  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (run) begin
            state     <= ARMED;
            bus.oBusy <= 1'b1;
          end
        end
        ARMED: begin
          if (!run) begin
            state     <= IDLE;
            bus.oBusy <= 1'b0;
          end else if (fb) begin
            state    <= PLAY;
            bus.oLed <= 1'b1;
          end
        end
        PLAY: begin
          if (fb && !run) begin
            state     <= IDLE;
            bus.oBusy <= 1'b0;
            bus.oLed  <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          bus.oBusy <= 1'b0;
          bus.oLed  <= 1'b0;
        end
      endcase
    end
  end

  // Read issue, valid alignment with the memory latency, and the colour register.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      bus.oMemAddr <= 20'd0;
      bus.oMemRE   <= 1'b0;
      vpipe        <= '0;
      bus.oRed     <= 10'd0;
      bus.oGreen   <= 10'd0;
      bus.oBlue    <= 10'd0;
      bus.oActive  <= 1'b0;
    end else begin
      bus.oMemRE <= hit;
      if (hit) begin
        bus.oMemAddr <= addr;
      end
      vpipe[0] <= bus.oMemRE;
      for (int i = 1; i < RD_LAT; i++) begin
        vpipe[i] <= vpipe[i-1];
      end
      if (vpipe[RD_LAT-1]) begin
        bus.oRed    <= bus.iMemData[9:0];
        bus.oGreen  <= bus.iMemData[9:0];
        bus.oBlue   <= bus.iMemData[9:0];
        bus.oActive <= 1'b1;
      end else begin
        bus.oRed    <= 10'd0;
        bus.oGreen  <= 10'd0;
        bus.oBlue   <= 10'd0;
        bus.oActive <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_frame_playback.sv
// Bench for frame_playback: three instances (RD_LAT 2, 1, 4) share one stimulus
// stream and are scored against a per-pixel expected-output queue.
module tb_frame_playback;
  localparam int H_START = 144;
  localparam int V_START = 35;
  localparam int H_RES   = 640;
  localparam int V_RES   = 480;
  localparam int NI      = 3;
  localparam int S_IDLE  = 0;
  localparam int S_ARMED = 1;
  localparam int S_PLAY  = 2;

  function automatic int rdl(input int i);
    return (i == 0) ? 2 : (i == 1) ? 1 : 4;
  endfunction

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        sw;
  logic        rdy;
  logic [12:0] cur_x;
  logic [12:0] cur_y;
  bit          rst_cmd;
  bit          sw_cmd;
  bit          rdy_cmd;

  frame_playback_if b0();
  frame_playback_if b1();
  frame_playback_if b2();

  frame_playback #(.RD_LAT(2)) dut0 (.iCLK(clk), .iRST_N(rst_n), .bus(b0.master));
  frame_playback #(.RD_LAT(1)) dut1 (.iCLK(clk), .iRST_N(rst_n), .bus(b1.master));
  frame_playback #(.RD_LAT(4)) dut2 (.iCLK(clk), .iRST_N(rst_n), .bus(b2.master));

  assign b0.iSwitch = sw;    assign b1.iSwitch = sw;    assign b2.iSwitch = sw;
  assign b0.iReady  = rdy;   assign b1.iReady  = rdy;   assign b2.iReady  = rdy;
  assign b0.iX      = cur_x; assign b1.iX      = cur_x; assign b2.iX      = cur_x;
  assign b0.iY      = cur_y; assign b1.iY      = cur_y; assign b2.iY      = cur_y;

  logic        act  [NI];
  logic [29:0] rgb  [NI];
  logic        re   [NI];
  logic [19:0] ma   [NI];
  logic        busy [NI];
  logic        led  [NI];

  assign act[0] = b0.oActive; assign rgb[0] = {b0.oRed, b0.oGreen, b0.oBlue};
  assign act[1] = b1.oActive; assign rgb[1] = {b1.oRed, b1.oGreen, b1.oBlue};
  assign act[2] = b2.oActive; assign rgb[2] = {b2.oRed, b2.oGreen, b2.oBlue};
  assign re[0] = b0.oMemRE; assign ma[0] = b0.oMemAddr; assign busy[0] = b0.oBusy; assign led[0] = b0.oLed;
  assign re[1] = b1.oMemRE; assign ma[1] = b1.oMemAddr; assign busy[1] = b1.oBusy; assign led[1] = b1.oLed;
  assign re[2] = b2.oMemRE; assign ma[2] = b2.oMemAddr; assign busy[2] = b2.oBusy; assign led[2] = b2.oLed;

  // ---------------- memory model: data = address[9:0], junk in [15:10] ----------------
  logic [19:0] mp [NI][4];
  logic [5:0]  junk;
  always @(posedge clk) begin
    junk <= 6'($urandom);
    for (int i = 0; i < NI; i++) begin
      for (int s = 3; s > 0; s--) mp[i][s] <= mp[i][s-1];
      mp[i][0] <= ma[i];
    end
  end
  assign b0.iMemData = {junk, mp[0][1][9:0]};
  assign b1.iMemData = {junk, mp[1][0][9:0]};
  assign b2.iMemData = {junk, mp[2][3][9:0]};

  // ---------------- scoreboard / reference model ----------------
  logic [10:0] exp_q [NI][$];
  int          n_cmp;
  int          n_err;
  int          mstate;
  bit          m_re;
  logic [19:0] m_addr;
  int          obs_act [NI];
  int          exp_act [NI];
  int          io_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit in_win(input int x, input int y);
    return (x >= H_START) && (x < H_START + H_RES) && (y >= V_START) && (y < V_START + V_RES);
  endfunction

  // One pixel clock: score outputs, apply new inputs, advance the model.
  task automatic step(input int x, input int y);
    logic [10:0] e;
    bit          hit;
    bit          go;
    int          a;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      e = exp_q[i].pop_front();
      if (e[10]) exp_act[i]++;
      if (act[i]) obs_act[i]++;
      if (act[i] || re[i]) io_seen++;
      check($sformatf("active%0d", i), 32'(act[i]), 32'(e[10]));
      check($sformatf("rgb%0d", i), 32'(rgb[i]), 32'({3{e[9:0]}}));
      check($sformatf("mem_re%0d", i), 32'(re[i]), 32'(m_re));
      check($sformatf("mem_addr%0d", i), 32'(ma[i]), 32'(m_addr));
      check($sformatf("busy%0d", i), 32'(busy[i]), 32'(mstate != S_IDLE));
      check($sformatf("led%0d", i), 32'(led[i]), 32'(mstate == S_PLAY));
    end
    rst_n = rst_cmd;
    sw    = sw_cmd;
    rdy   = rdy_cmd;
    cur_x = 13'(x);
    cur_y = 13'(y);
    if (!rst_n) begin
      m_re   = 1'b0;
      m_addr = '0;
      mstate = S_IDLE;
      for (int i = 0; i < NI; i++) exp_q[i].push_back('0);
    end else begin
      hit = (mstate == S_PLAY) && in_win(x, y);
      a   = (x - H_START) + H_RES * (y - V_START);
      m_re = hit;
      if (hit) m_addr = 20'(a);
      for (int i = 0; i < NI; i++) exp_q[i].push_back(hit ? {1'b1, a[9:0]} : 11'd0);
      go = sw_cmd && rdy_cmd;
      if (mstate == S_IDLE && go) mstate = S_ARMED;
      else if (mstate == S_ARMED && !go) mstate = S_IDLE;
      else if (mstate == S_ARMED && x == 0 && y == 0) mstate = S_PLAY;
      else if (mstate == S_PLAY && x == 0 && y == 0 && !go) mstate = S_IDLE;
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("%s_act%0d", tag, i), 32'(act[i]), 32'd0);
      check($sformatf("%s_rgb%0d", tag, i), 32'(rgb[i]), 32'd0);
      check($sformatf("%s_re%0d", tag, i), 32'(re[i]), 32'd0);
      check($sformatf("%s_addr%0d", tag, i), 32'(ma[i]), 32'd0);
      check($sformatf("%s_busy%0d", tag, i), 32'(busy[i]), 32'd0);
      check($sformatf("%s_led%0d", tag, i), 32'(led[i]), 32'd0);
    end
  endtask

  // Asynchronous reset in the middle of a cycle; in-flight pixels are lost.
  task automatic async_reset_pulse(input int hold);
    #2;
    rst_n   = 1'b0;
    rst_cmd = 1'b0;
    #1;
    check_all_zero("async_rst");
    for (int i = 0; i < NI; i++)
      for (int k = 0; k < exp_q[i].size(); k++) exp_q[i][k] = '0;
    m_re   = 1'b0;
    m_addr = '0;
    mstate = S_IDLE;
    repeat (hold) step(500, 300);
    rst_cmd = 1'b1;
  endtask

  // Sparse frame: FB, boundary-heavy sweeps on selected lines, then random pixels.
  task automatic frame_sparse(input int n_rand, input int drop_line, input bit chaos);
    int ys [10];
    int xs [12];
    int r;
    ys = '{34, 35, 36, $urandom_range(37, 199), 200, 201, $urandom_range(202, 512), 513, 514, 515};
    step(0, 0);
    foreach (ys[j]) begin
      if (ys[j] == drop_line) sw_cmd = 1'b0;
      if (chaos) begin
        sw_cmd  = ($urandom_range(0, 5) != 0);
        rdy_cmd = ($urandom_range(0, 5) != 0);
      end
      r  = $urandom_range(147, 770);
      xs = '{0, 143, 144, 145, 146, r, r + 1, r + 2, 782, 783, 784, 799};
      foreach (xs[k]) step(xs[k], ys[j]);
    end
    repeat (n_rand) step($urandom_range(1, 1023), $urandom_range(0, 600));
  endtask

  task automatic measure_latency();
    int seen [NI];
    repeat (8) step(790, 40);
    for (int i = 0; i < NI; i++) seen[i] = -1;
    step(300, 100);
    for (int k = 1; k <= 10; k++) begin
      step(790, 40);
      for (int i = 0; i < NI; i++) if (seen[i] < 0 && act[i]) seen[i] = k;
    end
    for (int i = 0; i < NI; i++) check($sformatf("latency%0d", i), 32'(seen[i]), 32'(rdl(i) + 2));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_cmp = 0; n_err = 0; io_seen = 0;
    mstate = S_IDLE; m_re = 1'b0; m_addr = '0;
    sw = 1'b0; rdy = 1'b0; cur_x = 13'd1; cur_y = 13'd1;
    sw_cmd = 1'b0; rdy_cmd = 1'b0; rst_cmd = 1'b0;
    for (int i = 0; i < NI; i++) begin
      obs_act[i] = 0;
      exp_act[i] = 0;
      repeat (rdl(i) + 2) exp_q[i].push_back('0);
    end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 check_all_zero("reset");
    repeat (3) step(10, 10);
    rst_cmd = 1'b1;
    step(10, 10);

    // Switch on but capture not ready: nothing may happen for two frames.
    sw_cmd = 1'b1; rdy_cmd = 1'b0; io_seen = 0;
    repeat (2) frame_sparse(40, -1, 1'b0);
    check("notready_quiet", 32'(io_seen), 32'd0);
    check("notready_busy", 32'(busy[0]), 32'd0);

    // Switch raised mid-frame: ARMED, then PLAY from the next frame boundary.
    sw_cmd = 1'b0; rdy_cmd = 1'b1;
    step(0, 0);
    repeat (20) step($urandom_range(150, 700), $urandom_range(40, 300));
    sw_cmd = 1'b1;
    step(300, 200);
    step(301, 200);
    check("armed_busy", 32'(busy[0]), 32'd1);
    check("armed_led", 32'(led[0]), 32'd0);
    step(0, 0);
    step(1, 0);
    check("play_led", 32'(led[0]), 32'd1);
    step(144, 35);
    step(145, 35);
    check("first_re", 32'(re[0]), 32'd1);
    check("first_addr", 32'(ma[0]), 32'd0);
    step(783, 514);
    step(784, 514);
    check("last_addr", 32'(ma[0]), 32'd307199);

    // Single pixel at (145,35) shows up four cycles later on the RD_LAT=2 instance.
    repeat (8) step(790, 40);
    step(145, 35);
    step(143, 35);
    step(784, 35);
    step(790, 35);
    step(795, 35);
    check("pix145_active", 32'(act[0]), 32'd1);
    check("pix145_red", 32'(b0.oRed), 32'd1);
    step(796, 35);
    check("pix143_active", 32'(act[0]), 32'd0);
    step(797, 35);
    check("pix784_active", 32'(act[0]), 32'd0);

    measure_latency();
    repeat (3) frame_sparse(150, -1, 1'b0);

    // Switch dropped at line 200: frame finishes, IDLE after next boundary.
    frame_sparse(100, 200, 1'b0);
    check("drop_still_play", 32'(led[0]), 32'd1);
    step(0, 0);
    step(1, 0);
    check("drop_idle", 32'(busy[0]), 32'd0);
    repeat (8) step(790, 40);
    io_seen = 0;
    frame_sparse(60, -1, 1'b0);
    check("drop_quiet", 32'(io_seen), 32'd0);

    // Reset pulse at (400,300) while playing.
    sw_cmd = 1'b1;
    step(5, 5);
    step(0, 0);
    for (int x = 144; x < 160; x++) step(x, 299);
    step(399, 300);
    step(400, 300);
    io_seen = 0;
    async_reset_pulse(3);
    for (int k = 0; k < 8; k++) step(401 + k, 300);
    check("post_rst_armed", 32'(busy[0]), 32'd1);
    check("post_rst_led", 32'(led[0]), 32'd0);
    check("post_rst_quiet", 32'(io_seen), 32'd0);
    frame_sparse(100, -1, 1'b0);
    check("replay_led", 32'(led[0]), 32'd1);

    // Random control activity across frames.
    repeat (16) begin
      sw_cmd  = ($urandom_range(0, 3) != 0);
      rdy_cmd = ($urandom_range(0, 3) != 0);
      frame_sparse($urandom_range(20, 120), ($urandom_range(0, 3) == 0) ? 200 : -1,
                   1'($urandom_range(0, 1)));
      if ($urandom_range(0, 4) == 0) begin
        step(400, 300);
        async_reset_pulse($urandom_range(1, 3));
      end
    end

    sw_cmd = 1'b0;
    repeat (10) step(790, 520);
    for (int i = 0; i < NI; i++) check($sformatf("act_total%0d", i), 32'(obs_act[i]), 32'(exp_act[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/frame_playback.md
FRAME_PLAYBACK -- requirements
Module: frame_playback

Interface
REQ-001 Parameter H_START, default 144: first active-video iX value.
REQ-002 Parameter V_START, default 35: first active-video iY value.
REQ-003 Parameter H_RES, default 640: stored frame width in pixels.
REQ-004 Parameter V_RES, default 480: stored frame height in lines.
REQ-005 Parameter RD_LAT, default 2, legal range 1-4: memory read latency in cycles from oMemAddr/oMemRE to valid iMemData.
REQ-006 iCLK  in  1  pixel clock, same as the VGA controller; the block's only clock.
REQ-007 iRST_N  in  1  asynchronous, active-low reset.
REQ-008 iSwitch  in  1  playback request level (slide switch); 1 = play stored frame, 0 = stop.
REQ-009 iReady  in  1  capture-complete flag from the frame writer; playback is allowed only while it is 1.
REQ-010 iX  in  13  current VGA horizontal coordinate.
REQ-011 iY  in  13  current VGA vertical coordinate.
REQ-012 oMemAddr  out  20  memory read address.
REQ-013 oMemRE  out  1  memory read enable.
REQ-014 iMemData  in  16  memory read data; [9:0] holds the stored 10-bit intensity.
REQ-015 oRed, oGreen, oBlue  out  10 each  pixel colour to the VGA controller.
REQ-016 oActive  out  1  high when oRed/oGreen/oBlue carry stored pixel data.
REQ-017 oBusy  out  1  high in states ARMED and PLAY.
REQ-018 oLed  out  1  status LED; equals 1 in state PLAY.

Function
REQ-019 Frame boundary event FB: single-cycle condition iX == 0 and iY == 0.
REQ-020 States: IDLE, ARMED, PLAY; encoded, one state register.
REQ-021 IDLE -> ARMED when iSwitch == 1 and iReady == 1; otherwise stay in IDLE.
REQ-022 ARMED -> PLAY on FB; ARMED -> IDLE if iSwitch == 0 or iReady == 0 before FB.
REQ-023 PLAY -> IDLE on FB when iSwitch == 0 or iReady == 0 sampled on that cycle; otherwise stay in PLAY; a frame in progress is never truncated.
REQ-024 Window W: H_START <= iX <= H_START+H_RES-1 and V_START <= iY <= V_START+V_RES-1; both bounds inclusive, exactly H_RES x V_RES pixels.
REQ-025 Stage 1, registered: in PLAY with iX, iY in W, oMemAddr = (iX-H_START) + H_RES*(iY-V_START), oMemRE = 1; otherwise oMemRE = 0 and oMemAddr holds its previous value.
REQ-026 Address arithmetic is evaluated at 20 bits; maximum address H_RES*V_RES-1 (307199 at defaults); no wrap within W.
REQ-027 A valid shift register of depth RD_LAT carries oMemRE alongside the outstanding read.
REQ-028 Output stage, registered: when the delayed valid is 1, oRed = oGreen = oBlue = iMemData[9:0] and oActive = 1; otherwise all three colours = 0 and oActive = 0.
REQ-029 Latency: iX/iY sample to colour output = RD_LAT+2 cycles, fixed, with no bubbles inside a line.
REQ-030 Transition PLAY -> IDLE stops issuing new reads immediately; reads already in the pipe still drain to the outputs.
REQ-031 iMemData[15:10] are ignored.

Reset
REQ-032 iRST_N low asynchronously forces state IDLE, clears the valid pipe, and sets oMemAddr = 0, oMemRE = 0, oRed = oGreen = oBlue = 0, oActive = 0, oBusy = 0, oLed = 0.
REQ-033 Reset asserted mid-frame discards all in-flight reads; after release, the block returns to ARMED or PLAY only through REQ-021/022.
REQ-034 Reset release is synchronous to iCLK; first state evaluation happens on the first rising edge with iRST_N high.

Verification
REQ-035 iSwitch = 1, iReady = 0 for 2 frames -> state IDLE, oMemRE never 1, oActive never 1.
REQ-036 iReady = 1, iSwitch raised mid-frame -> ARMED; PLAY entered at next (0,0); first read at (144,35) gives oMemAddr = 0; last read at (783,514) gives oMemAddr = 307199.
REQ-037 Memory model returns data = address[9:0] with RD_LAT = 2 -> a pixel at (145,35) appears 4 cycles later as oRed = oGreen = oBlue = 1 with oActive = 1; (143,35) and (784,35) give oActive = 0.
REQ-038 iSwitch dropped at line 200 of a PLAY frame -> remaining lines still read; state IDLE after the next (0,0); no oMemRE afterwards.
REQ-039 iRST_N pulsed low at (400,300) during PLAY -> all outputs 0 within the same cycle; no oActive pulse from drained reads; replay resumes only after ARMED and then FB.
REQ-040 Sweep RD_LAT over 1 and 4 -> latency equals RD_LAT+2 and active pixel count per frame equals 307200.
